// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared types and defaults for the data-memory responder.
//   dmem_state_e   responder FSM state encoding
//   DMEM_DATA_W    default data word width
//   DMEM_ADDR_W    default address width (depth = 2**DMEM_ADDR_W)
//   DMEM_MAX_WAIT  largest legal number of wait states
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

    localparam int unsigned DMEM_DATA_W   = 8;
    localparam int unsigned DMEM_ADDR_W   = 8;
    localparam int unsigned DMEM_MAX_WAIT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// 2**ADDR_W x DATA_W storage: synchronous write, asynchronous read, no reset.
// Ports:
//   clk_i    in   clock
//   we_i     in   write enable, commits wdata_i at addr_i on the rising edge
//   addr_i   in   word address shared by read and write
//   wdata_i  in   write data
//   rdata_o  out  combinational read of the word at addr_i
// -----------------------------------------------------------------------------
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DATA_W = DMEM_DATA_W,
    parameter int unsigned ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Far end of the data-memory address path: accepts one request at a time,
// reads or writes the storage array, and returns a registered response.
// Ports:
//   clk_i        in   clock
//   rst_ni       in   asynchronous active-low reset
//   req_valid_i  in   request present
//   req_ready_o  out  responder can accept a request (registered)
//   req_we_i     in   1 = write, 0 = read
//   req_addr_i   in   word address
//   req_wdata_i  in   write data
//   rsp_valid_o  out  response present (registered)
//   rsp_ready_i  in   consumer takes the response
//   rsp_rdata_o  out  read data, or echo of the written data for writes
//   rsp_we_o     out  response belongs to a write
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; a write commits on the accept edge
// WAIT  | counting down wait states before the response
// RESP  | response held on the outputs until rsp_ready_i
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DATA_W      = DMEM_DATA_W,
    parameter int unsigned ADDR_W      = DMEM_ADDR_W,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_we_o
);

    if (WAIT_CYCLES > DMEM_MAX_WAIT) begin : g_bad_wait_cycles
        $fatal(1, "dmem_responder: WAIT_CYCLES=%0d outside 0..15", WAIT_CYCLES);
    end

    // Counter is loaded with WAIT_CYCLES-1 so WAIT lasts exactly WAIT_CYCLES cycles.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_we_q, rsp_we_d;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_rdata;

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .addr_i  (arr_addr),
        .wdata_i (wdata_d),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_we_d    = rsp_we_q;
        arr_we      = 1'b0;
        // In IDLE the array looks at the live request address so a zero-wait
        // read can be sampled on the accept edge; otherwise the latched one.
        arr_addr    = addr_q;

        case (state_q)
            IDLE: begin
                arr_addr = req_addr_i;
                if (req_valid_i && req_ready_q) begin
                    addr_d  = req_addr_i;
                    we_d    = req_we_i;
                    wdata_d = req_wdata_i;
                    arr_we  = req_we_i;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d     = RESP;
                        rsp_we_d    = req_we_i;
                        rsp_rdata_d = req_we_i ? req_wdata_i : arr_rdata;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    rsp_we_d    = we_q;
                    rsp_rdata_d = we_q ? wdata_q : arr_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_we_q    <= rsp_we_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_we_o    = rsp_we_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Two responders side by side: index 0 has no wait states, index 1 has three.
// Requests push their expected response into a per-responder queue; a monitor
// pops and compares on every response handshake.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst_n;
    logic [1:0]      req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_we;
    logic [1:0][7:0] req_addr, req_wdata, rsp_rdata;

    dmem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i       (clk),
        .rst_ni      (rst_n[0]),
        .req_valid_i (req_valid[0]),
        .req_ready_o (req_ready[0]),
        .req_we_i    (req_we[0]),
        .req_addr_i  (req_addr[0]),
        .req_wdata_i (req_wdata[0]),
        .rsp_valid_o (rsp_valid[0]),
        .rsp_ready_i (rsp_ready[0]),
        .rsp_rdata_o (rsp_rdata[0]),
        .rsp_we_o    (rsp_we[0])
    );

    dmem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(3)) u_dut3 (
        .clk_i       (clk),
        .rst_ni      (rst_n[1]),
        .req_valid_i (req_valid[1]),
        .req_ready_o (req_ready[1]),
        .req_we_i    (req_we[1]),
        .req_addr_i  (req_addr[1]),
        .req_wdata_i (req_wdata[1]),
        .rsp_valid_o (rsp_valid[1]),
        .rsp_ready_i (rsp_ready[1]),
        .rsp_rdata_o (rsp_rdata[1]),
        .rsp_we_o    (rsp_we[1])
    );

    typedef struct packed {
        logic       we;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q0[$];
    exp_t       exp_q1[$];
    logic [7:0] mdl [2][256];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rnd_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string msg);
        n_checks++;
        n_fail++;
        $display("FAIL %s", msg);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   have;
        for (int s = 0; s < 2; s++) begin
            if (rst_n[s] === 1'b1 && rsp_valid[s] === 1'b1 && rsp_ready[s] === 1'b1) begin
                have = 1'b0;
                if (s == 0 && exp_q0.size() > 0) begin
                    e = exp_q0.pop_front();
                    have = 1'b1;
                end else if (s == 1 && exp_q1.size() > 0) begin
                    e = exp_q1.pop_front();
                    have = 1'b1;
                end
                if (!have) begin
                    fail_now($sformatf("unexpected_rsp dut%0d: got data 0x%0h, expected no response", s, rsp_rdata[s]));
                end else begin
                    chk($sformatf("rsp_rdata dut%0d", s), 32'(rsp_rdata[s]), 32'(e.data));
                    chk($sformatf("rsp_we dut%0d", s), 32'(rsp_we[s]), 32'(e.we));
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_en) rsp_ready[0] = ($urandom_range(0, 3) != 0);
    end

    // Caller must be at posedge+#1; returns at posedge+#1 after the accept edge.
    task automatic issue(input int s, input logic we, input logic [7:0] a,
                         input logic [7:0] d, output int acc);
        exp_t e;
        bit   ok;
        ok  = 1'b0;
        acc = -1;
        req_we[s]    = we;
        req_addr[s]  = a;
        req_wdata[s] = d;
        req_valid[s] = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[s] === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            fail_now($sformatf("accept_timeout dut%0d: req_ready 0, expected 1", s));
            req_valid[s] = 1'b0;
            return;
        end
        if (we) mdl[s][a] = d;
        e.we   = we;
        e.data = we ? d : mdl[s][a];
        if (s == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid[s] = 1'b0;
    endtask

    // Returns at the first negedge where rsp_valid is seen high.
    task automatic wait_rsp(input int s, input bit chk_ready_low, output int m);
        bit ok;
        ok = 1'b0;
        m  = -1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (chk_ready_low) chk("req_ready_low_while_busy", 32'(req_ready[s]), 32'd0);
            if (rsp_valid[s] === 1'b1) begin
                ok = 1'b1;
                m  = cyc;
            end
        end
        if (!ok) fail_now($sformatf("rsp_timeout dut%0d: rsp_valid 0, expected 1", s));
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acc, acc2, m;
        logic [7:0] hold;
        bit bad;

        rst_n     = 2'b00;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 2'b11;

        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset req_ready dut%0d", s), 32'(req_ready[s]), 32'd1);
            chk($sformatf("reset rsp_valid dut%0d", s), 32'(rsp_valid[s]), 32'd0);
            chk($sformatf("reset rsp_rdata dut%0d", s), 32'(rsp_rdata[s]), 32'd0);
            chk($sformatf("reset rsp_we dut%0d", s), 32'(rsp_we[s]), 32'd0);
        end
        rst_n = 2'b11;
        sync();

        // Zero wait states: write then read 0x3C.
        issue(0, 1'b1, 8'h3C, 8'hA5, acc);
        wait_rsp(0, 1'b0, m);
        chk("latency w0 write", 32'((m + 1) - acc), 32'd1);
        sync();
        issue(0, 1'b0, 8'h3C, 8'h00, acc);
        wait_rsp(0, 1'b0, m);
        chk("latency w0 read", 32'((m + 1) - acc), 32'd1);
        sync();

        // Three wait states.
        issue(1, 1'b1, 8'h20, 8'h5E, acc);
        wait_rsp(1, 1'b0, m);
        sync();
        issue(1, 1'b0, 8'h20, 8'h00, acc);
        wait_rsp(1, 1'b1, m);
        chk("latency w3 read", 32'((m + 1) - acc), 32'd4);
        @(negedge clk);
        chk("w3 ready after handshake", 32'(req_ready[1]), 32'd1);
        chk("w3 valid after handshake", 32'(rsp_valid[1]), 32'd0);
        sync();

        // Backpressure: response held, competing request ignored.
        rsp_ready[1] = 1'b0;
        issue(1, 1'b0, 8'h20, 8'h00, acc);
        wait_rsp(1, 1'b0, m);
        hold = rsp_rdata[1];
        chk("bp first data", 32'(hold), 32'h5E);
        req_we[1]    = 1'b1;
        req_addr[1]  = 8'h20;
        req_wdata[1] = 8'hC3;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp rsp_valid held", 32'(rsp_valid[1]), 32'd1);
            chk("bp rsp_rdata held", 32'(rsp_rdata[1]), 32'h5E);
            chk("bp req_ready low", 32'(req_ready[1]), 32'd0);
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        chk("bp ready after release", 32'(req_ready[1]), 32'd1);
        sync();
        issue(1, 1'b0, 8'h20, 8'h00, acc);
        wait_rsp(1, 1'b0, m);
        sync();

        // Back-to-back on zero-wait responder.
        issue(0, 1'b1, 8'hFF, 8'h00, acc);
        issue(0, 1'b0, 8'hFF, 8'h00, acc2);
        chk("b2b accept spacing", 32'(acc2 - acc), 32'd2);
        wait_rsp(0, 1'b0, m);
        sync();

        // Reset in the middle of WAIT after a write.
        issue(1, 1'b1, 8'h80, 8'h11, acc);
        #2;
        rst_n[1] = 1'b0;
        #1;
        chk("midreset req_ready", 32'(req_ready[1]), 32'd1);
        chk("midreset rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("midreset rsp_rdata", 32'(rsp_rdata[1]), 32'd0);
        chk("midreset rsp_we", 32'(rsp_we[1]), 32'd0);
        exp_q1.delete();
        @(negedge clk);
        rst_n[1] = 1'b1;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b0) bad = 1'b1;
        end
        chk("midreset no response", 32'(bad), 32'd0);
        sync();
        issue(1, 1'b0, 8'h80, 8'h00, acc);
        wait_rsp(1, 1'b0, m);
        sync();

        // Fill zero-wait array, then random traffic with response stalls.
        for (int a = 0; a < 256; a++) begin
            issue(0, 1'b1, 8'(a), 8'(a) ^ 8'h5A, acc);
        end
        rnd_en = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            issue(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), acc);
        end
        rnd_en = 1'b0;
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 100 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) begin
            @(negedge clk);
        end
        chk("pending responses drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
